// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Serialises instruction-fetch and data-memory accesses onto one single-port memory,
// one transaction outstanding at a time, with fixed data-over-fetch priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [AW-1:0]    if_addr,
  output logic [DW-1:0]    if_rdata,
  output logic             if_valid,
  output logic             if_wait,
  input  logic             dm_req,
  input  logic             dm_we,
  input  logic [AW-1:0]    dm_addr,
  input  logic [DW-1:0]    dm_wdata,
  output logic [DW-1:0]    dm_rdata,
  output logic             dm_valid,
  output logic             dm_wait,
  output logic             mem_req,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [DW-1:0]    mem_rdata,
  output logic [CNT_W-1:0] conflict_cnt
);

  arb_state_t state;
  arb_owner_t owner;

  // Wait drops in the valid-pulse cycle so the core advances on that same edge.
  assign if_wait = if_req & ~if_valid;
  assign dm_wait = dm_req & ~dm_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      owner     <= OWN_I;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_valid  <= 1'b0;
      dm_valid  <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (dm_req) begin
            owner     <= OWN_D;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            state     <= REQ;
          end else if (if_req) begin
            owner     <= OWN_I;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            state     <= REQ;
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            if (owner == OWN_D) begin
              dm_rdata <= mem_rdata;
              dm_valid <= 1'b1;
            end else begin
              if_rdata <= mem_rdata;
              if_valid <= 1'b1;
            end
            state <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Counts fetch losing arbitration; saturates rather than wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflict_cnt <= '0;
    end else if (state == IDLE && if_req && dm_req && conflict_cnt != '1) begin
      conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a small behavioural memory.
module tb_mem_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             if_req;
  logic [AW-1:0]    if_addr;
  logic [DW-1:0]    if_rdata;
  logic             if_valid;
  logic             if_wait;
  logic             dm_req;
  logic             dm_we;
  logic [AW-1:0]    dm_addr;
  logic [DW-1:0]    dm_wdata;
  logic [DW-1:0]    dm_rdata;
  logic             dm_valid;
  logic             dm_wait;
  logic             mem_req;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata;
  logic             mem_gnt;
  logic             mem_rvalid;
  logic [DW-1:0]    mem_rdata;
  logic [CNT_W-1:0] conflict_cnt;

  int vectors;
  int miscompares;
  logic [31:0] mem_model [logic [31:0]];

  mem_arbiter #(.AW(AW), .DW(DW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_valid(if_valid), .if_wait(if_wait),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_wait(dm_wait),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_if_rdata"}, if_rdata, 32'h0);
    chk({tag, "_dm_rdata"}, dm_rdata, 32'h0);
    chk({tag, "_valids"}, {30'h0, if_valid, dm_valid}, 32'h0);
    chk({tag, "_waits"}, {30'h0, if_wait, dm_wait}, 32'h0);
    chk({tag, "_mem_req_we"}, {30'h0, mem_req, mem_we}, 32'h0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    chk({tag, "_cnt"}, 32'(conflict_cnt), 32'h0);
  endtask

  // Memory responder: grants after gd extra cycles, responds rd cycles after grant.
  // Returns at the negedge of the requester's valid-pulse cycle.
  task automatic serve(input int gd, input int rd);
    logic [31:0] a;
    logic [31:0] d;
    logic        w;
    int          n;
    n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mem_req_up", 32'(mem_req), 32'd1);
    a = mem_addr;
    w = mem_we;
    d = mem_wdata;
    for (int i = 0; i < gd; i++) begin
      @(negedge clk);
      chk("bp_req_hold", 32'(mem_req), 32'd1);
      chk("bp_addr_hold", mem_addr, a);
      chk("bp_wait_hi", 32'(if_wait | dm_wait), 32'd1);
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    if (w) mem_model[a] = d;
    for (int i = 0; i < rd; i++) begin
      chk("rv_wait_hi", 32'(if_wait | dm_wait), 32'd1);
      @(negedge clk);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = (!w && mem_model.exists(a)) ? mem_model[a] : 32'h0;
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    if_req      = 1'b0;
    if_addr     = '0;
    dm_req      = 1'b0;
    dm_we       = 1'b0;
    dm_addr     = '0;
    dm_wdata    = '0;
    mem_gnt     = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rdata   = '0;
    mem_model[32'h10] = 32'h0051_3023;
    mem_model[32'h20] = 32'h00A0_0093;

    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Fetch only: minimum latency path.
    if_req  = 1'b1;
    if_addr = 32'h10;
    @(negedge clk);
    chk("f_mem_req", 32'(mem_req), 32'd1);
    chk("f_mem_addr", mem_addr, 32'h10);
    chk("f_mem_we", 32'(mem_we), 32'd0);
    serve(0, 0);
    chk("f_if_valid", 32'(if_valid), 32'd1);
    chk("f_if_rdata", if_rdata, 32'h0051_3023);
    chk("f_dm_valid", 32'(dm_valid), 32'd0);
    chk("f_if_wait", 32'(if_wait), 32'd0);
    if_req = 1'b0;
    @(negedge clk);
    chk("f_pulse_end", 32'(if_valid), 32'd0);
    chk("f_dm_valid2", 32'(dm_valid), 32'd0);

    // Simultaneous: data store wins, fetch follows.
    if_req   = 1'b1;
    if_addr  = 32'h20;
    dm_req   = 1'b1;
    dm_we    = 1'b1;
    dm_addr  = 32'h100;
    dm_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("s_mem_we", 32'(mem_we), 32'd1);
    chk("s_mem_addr", mem_addr, 32'h100);
    chk("s_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("s_cnt", 32'(conflict_cnt), 32'd1);
    serve(0, 0);
    chk("s_dm_valid", 32'(dm_valid), 32'd1);
    chk("s_if_valid", 32'(if_valid), 32'd0);
    chk("s_if_wait", 32'(if_wait), 32'd1);
    chk("s_dm_wait", 32'(dm_wait), 32'd0);
    dm_req = 1'b0;
    dm_we  = 1'b0;
    @(negedge clk);
    chk("s_idle_gap", 32'(mem_req), 32'd0);
    @(negedge clk);
    chk("s_f_addr", mem_addr, 32'h20);
    chk("s_f_we", 32'(mem_we), 32'd0);
    serve(0, 0);
    chk("s_f_valid", 32'(if_valid), 32'd1);
    chk("s_f_rdata", if_rdata, 32'h00A0_0093);
    chk("s_cnt_hold", 32'(conflict_cnt), 32'd1);
    if_req = 1'b0;
    @(negedge clk);

    // Back-pressure: late grant, late response, load of the stored word.
    dm_req  = 1'b1;
    dm_addr = 32'h100;
    @(negedge clk);
    dm_addr = 32'h999;
    serve(5, 3);
    chk("bp_dm_valid", 32'(dm_valid), 32'd1);
    chk("bp_dm_rdata", dm_rdata, 32'hDEAD_BEEF);
    chk("bp_dm_wait", 32'(dm_wait), 32'd0);
    dm_req = 1'b0;
    @(negedge clk);
    chk("bp_one_pulse", 32'(dm_valid), 32'd0);
    chk("bp_rdata_hold", dm_rdata, 32'hDEAD_BEEF);

    // Load after store.
    dm_req   = 1'b1;
    dm_we    = 1'b1;
    dm_addr  = 32'h200;
    dm_wdata = 32'h1234_5678;
    serve(0, 0);
    chk("ls_st_valid", 32'(dm_valid), 32'd1);
    dm_req = 1'b0;
    dm_we  = 1'b0;
    @(negedge clk);
    dm_req = 1'b1;
    serve(0, 0);
    chk("ls_ld_valid", 32'(dm_valid), 32'd1);
    chk("ls_ld_rdata", dm_rdata, 32'h1234_5678);
    dm_req = 1'b0;
    @(negedge clk);

    // Saturation: both held, data re-arbitrates every IDLE.
    if_req  = 1'b1;
    if_addr = 32'h10;
    dm_req  = 1'b1;
    dm_addr = 32'h300;
    for (int i = 0; i < 20; i++) begin
      serve(0, 0);
      chk("sat_dm_valid", 32'(dm_valid), 32'd1);
      chk("sat_cnt", 32'(conflict_cnt), (2 + i > 15) ? 32'd15 : 32'(2 + i));
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    @(negedge clk);
    chk("sat_final", 32'(conflict_cnt), 32'd15);

    // Reset while waiting for the memory response.
    if_req  = 1'b1;
    if_addr = 32'h10;
    @(negedge clk);
    chk("r_mem_req", 32'(mem_req), 32'd1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("r_in_wait", 32'(mem_req), 32'd0);
    if_req = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("r_async");
    @(negedge clk);
    rst        = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hBAD0_BAD0;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("r_late_valid", {30'h0, if_valid, dm_valid}, 32'h0);
    chk("r_late_rdata", if_rdata, 32'h0);
    @(negedge clk);
    chk("r_late_valid2", {30'h0, if_valid, dm_valid}, 32'h0);
    chk("r_idle", 32'(mem_req), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares one single-port unified memory between the pipelined core's instruction-fetch port (pcF/InstrF) and its data-memory port (ALUResultM/WriteDataM/MemWriteM/ReadDataM). It sits between `processor` and the memory macro, serialises accesses with one transaction outstanding at a time, and tells the core when each port is waiting. The core's hazard logic consumes `if_wait`/`dm_wait` as extra stall sources.

## Interface
- Parameters:
  - `AW`, 32, address width.
  - `DW`, 32, data width.
  - `CNT_W`, 16, width of the saturating conflict counter.
- Ports:
  - `clk  in  1  system clock.`
  - `rst  in  1  reset; one clock, asynchronous, active-low.`
  - `if_req  in  1  fetch request, level, held until if_valid.`
  - `if_addr  in  AW  fetch address.`
  - `if_rdata  out  DW  fetched instruction, valid with if_valid.`
  - `if_valid  out  1  one-cycle completion pulse, fetch side.`
  - `if_wait  out  1  if_req & ~if_valid.`
  - `dm_req  in  1  data request, level, held until dm_valid.`
  - `dm_we  in  1  1 = write.`
  - `dm_addr  in  AW  data address.`
  - `dm_wdata  in  DW  store data.`
  - `dm_rdata  out  DW  load data, valid with dm_valid.`
  - `dm_valid  out  1  one-cycle completion pulse, data side; loads and stores.`
  - `dm_wait  out  1  dm_req & ~dm_valid.`
  - `mem_req  out  1  memory request, held until mem_gnt.`
  - `mem_we  out  1  write enable.`
  - `mem_addr  out  AW  memory address.`
  - `mem_wdata  out  DW  memory write data.`
  - `mem_gnt  in  1  memory accepted the request this cycle.`
  - `mem_rvalid  in  1  response; read data or write acknowledge.`
  - `mem_rdata  in  DW  memory read data.`
  - `conflict_cnt  out  CNT_W  cycles in which fetch lost arbitration, saturating.`

## Operation
- FSM states:
  - IDLE: arbitrate. If `dm_req`, choose owner D; else if `if_req`, choose owner I. Latch the owner's addr/we/wdata; fetch always uses we = 0. Go to REQ.
  - REQ: `mem_req` = 1 with the latched fields. On `mem_gnt`, go to WAIT.
  - WAIT: on `mem_rvalid`, capture `mem_rdata` into the owner's rdata register and go to RESP.
  - RESP: pulse the owner's `*_valid` for exactly one cycle, then go to IDLE.
- Priority is fixed: data beats fetch. The data request belongs to the older instruction, and a data-stalled pipeline stops issuing new data requests, so fetch cannot starve.
- Request fields are latched at arbitration. Requester inputs that change later are ignored until the next IDLE.
- If a requester drops `*_req` mid-transaction, that is a protocol violation. The transaction still completes and `*_valid` still pulses.
- `mem_rvalid` is ignored in IDLE, REQ and RESP.
- For stores, `dm_rdata` is updated with whatever `mem_rdata` holds (don't-care). Bench ignores it.
- `if_rdata` and `dm_rdata` hold their last captured value between transactions.
- Conflict counter:
  - `conflict_cnt` increments in every IDLE cycle where `if_req & dm_req`.
  - It saturates at all-ones and never wraps.

## Timing
- Reset (asynchronous, `rst` = 0):
  - State = IDLE.
  - All outputs = 0, including `if_rdata`, `dm_rdata` and `conflict_cnt`.
  - An outstanding memory response arriving after reset is discarded.
- Minimum latency, with `mem_gnt` in the first REQ cycle and `mem_rvalid` the cycle after:
  - `*_req` first sampled in cycle 0.
  - `mem_req` high in cycle 1.
  - `mem_rvalid` in cycle 2.
  - `*_valid` in cycle 3.
  - Back-to-back throughput is one transaction per 4 cycles.
- `mem_req`/`mem_we`/`mem_addr`/`mem_wdata` are registered and decoded from state. They stay stable from REQ entry until the `mem_gnt` cycle inclusive.
- `*_wait` is combinational from `*_req` and the `*_valid` register. It is 0 in the pulse cycle, so the core advances on that same edge.
- Requester side:
  - A requester may re-assert `*_req` in the cycle after its `*_valid`.
  - That request is sampled in the following IDLE.

## Structure
- Shared package `mem_arb_pkg`:
  - `arb_state_t` enum {IDLE, REQ, WAIT, RESP}.
  - `arb_owner_t` enum {OWN_I, OWN_D}.
- Single module. The conflict counter is inline (under 15 lines) and does not get its own sub-module.
- Expected size is about 150–200 RTL lines.

## Test plan
- Fetch only:
  - Stimulus: `if_req` = 1, `if_addr` = 0x0000_0010; memory grants immediately and returns 0x0051_3023 one cycle later.
  - Required: `mem_addr` = 0x10 and `mem_we` = 0 in cycle 1; `if_valid` and `if_rdata` = 0x0051_3023 in cycle 3; `dm_valid` never asserts.
- Simultaneous requests:
  - Stimulus: `if_req` = `dm_req` = 1; store with `dm_addr` = 0x100, `dm_wdata` = 0xDEAD_BEEF.
  - Required: the first memory transaction is a write to 0x100; the fetch follows from the next IDLE; `conflict_cnt` = 1.
- Memory back-pressure:
  - Stimulus: `mem_gnt` held low 5 cycles, then `mem_rvalid` delayed 3 cycles.
  - Required: `mem_req`/`mem_addr` stable throughout; exactly one `*_valid` pulse; `*_wait` high until that pulse.
- Reset mid-transaction:
  - Stimulus: `rst` low while in WAIT, then `mem_rvalid` = 1 after reset release.
  - Required: all outputs 0 immediately (asynchronously); the late response is ignored; no `*_valid` pulse.
- Counter saturation:
  - Stimulus: `CNT_W` = 4, 20 conflict cycles.
  - Required: `conflict_cnt` stops at 15.
- Load after store:
  - Stimulus: store 0x1234_5678 to 0x200, then load from 0x200 with a memory model.
  - Required: `dm_rdata` = 0x1234_5678 on the load's `dm_valid`.
